// File: rtl/multibyte_add_seq_pkg.sv
// Shared types and defaults for the byte-serial multi-byte adder.
package add_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_BYTES_DEF = 4;

endpackage

// File: rtl/multibyte_add_seq_fa.sv
// 8-bit adder with carry in/out; the only carry chain in the block.
module FullAdder8Bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial packet adder, LSB first, with a one-entry registered output.
module multibyte_add_seq
    import add_seq_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_a,
    input  logic [7:0] s_b,
    input  logic       s_cin,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_sum,
    output logic       m_last,
    output logic       m_cout,
    output logic       m_ovf,
    output logic       m_trunc
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_carry;

    logic          r_m_valid;
    logic [7:0]    r_m_sum;
    logic          r_m_last;
    logic          r_m_cout;
    logic          r_m_ovf;
    logic          r_m_trunc;

    logic          w_acc;
    logic          w_first;
    logic          w_at_max;
    logic          w_end;
    logic          w_cin;
    logic [7:0]    w_sum;
    logic          w_cout;
    logic          w_ovf;

    assign s_ready  = !r_m_valid || m_ready;
    assign w_acc    = s_valid && s_ready;
    assign w_first  = (r_state == IDLE);
    assign w_at_max = w_first ? (MAX_BYTES == 1)
                              : (r_cnt == CW'(MAX_BYTES - 1));
    assign w_end    = s_last || w_at_max;
    assign w_cin    = w_first ? s_cin : r_carry;
    assign w_ovf    = (s_a[7] == s_b[7]) && (w_sum[7] != s_a[7]);

    FullAdder8Bit u_fa (
        .i_a    (s_a),
        .i_b    (s_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc) begin
                r_carry <= w_cout;
            end
        end
    end

    // A packet ends on s_last or when the MAX_BYTES-th byte forces it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_acc) begin
            if (w_end) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_sum   <= '0;
            r_m_last  <= 1'b0;
            r_m_cout  <= 1'b0;
            r_m_ovf   <= 1'b0;
            r_m_trunc <= 1'b0;
        end else if (w_acc) begin
            r_m_valid <= 1'b1;
            r_m_sum   <= w_sum;
            r_m_last  <= w_end;
            r_m_cout  <= w_end && w_cout;
            r_m_ovf   <= w_end && w_ovf;
            r_m_trunc <= w_at_max && !s_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_sum   = r_m_sum;
    assign m_last  = r_m_last;
    assign m_cout  = r_m_cout;
    assign m_ovf   = r_m_ovf;
    assign m_trunc = r_m_trunc;

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, giving the maximum number of bytes per operand packet (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port s_valid, input, 1, upstream byte pair valid.
REQ-005 SHALL have port s_ready, output, 1, block can accept a byte pair.
REQ-006 SHALL have ports s_a and s_b, input, 8 each, operand bytes, least-significant byte first.
REQ-007 SHALL have port s_cin, input, 1, packet carry-in; sampled on the first byte of a packet only.
REQ-008 SHALL have port s_last, input, 1, marks the final (most-significant) byte of a packet.
REQ-009 SHALL have port m_valid, output, 1, result byte valid.
REQ-010 SHALL have port m_ready, input, 1, downstream accepts the result byte.
REQ-011 SHALL have port m_sum, output, 8, result byte.
REQ-012 SHALL have port m_last, output, 1, final result byte of a packet.
REQ-013 SHALL have port m_cout, output, 1, unsigned carry-out; meaningful only when m_last=1, else 0.
REQ-014 SHALL have port m_ovf, output, 1, signed overflow of the packet; meaningful only when m_last=1, else 0.
REQ-015 SHALL have port m_trunc, output, 1, asserted with m_last when the packet was force-terminated at MAX_BYTES.

Function
REQ-016 SHALL add packets byte-serially: each accepted pair yields exactly one result byte, with sum = s_a + s_b + carry (mod 256).
REQ-017 SHALL define carry as s_cin on the first byte of a packet, else the carry-out of the previous byte.
REQ-018 SHALL accept an input pair on a cycle where s_valid && s_ready.
REQ-019 SHALL transfer an output byte on a cycle where m_valid && m_ready.
REQ-020 SHALL drive s_ready = !m_valid || m_ready, allowing one transfer per cycle at full throughput.
REQ-021 SHALL register the result: fixed latency of 1 cycle from input acceptance to m_valid.
REQ-022 SHALL hold m_sum, m_last, m_cout, m_ovf and m_trunc stable while m_valid && !m_ready.
REQ-023 SHALL implement FSM IDLE -> RUN on accepting a non-last byte.
REQ-024 SHALL transition RUN -> IDLE on accepting a last byte, or on the MAX_BYTES-th byte.
REQ-025 SHALL transition IDLE -> IDLE on accepting a single-byte packet.
REQ-026 SHALL keep a byte counter that clears in IDLE and increments per accepted byte in RUN.
REQ-027 SHALL force m_last=1 and m_trunc=1 when the MAX_BYTES-th byte arrives without s_last; the next byte starts a new packet.
REQ-028 SHALL set m_trunc=0 when s_last coincides with the MAX_BYTES-th byte.
REQ-029 SHALL compute m_ovf on the last byte as (s_a[7]==s_b[7]) && (sum[7]!=s_a[7]).
REQ-030 SHALL ignore s_a, s_b, s_cin and s_last when s_valid=0; no state changes.
REQ-031 SHALL leave state unchanged when s_valid=1 and s_ready=0; upstream holds its data.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force FSM to IDLE, counter=0, carry=0, and m_valid, m_sum, m_last, m_cout, m_ovf, m_trunc all to 0.
REQ-033 SHALL hold s_ready=1 during reset.
REQ-034 SHALL, on reset mid-packet, discard the partial packet; the first byte after reset release is a first byte.

Structure
REQ-035 SHALL place FSM state encoding (IDLE, RUN) and MAX_BYTES default in shared package add_seq_pkg.
REQ-036 SHALL instantiate exactly one FullAdder8Bit for the byte addition; carry chain logic SHALL not be duplicated.

Verification
REQ-037 SHALL cover: 2-byte packet 0x12FF + 0x0001, cin=0 -> bytes 0x00, 0x13; m_cout=0, m_ovf=0.
REQ-038 SHALL cover: 1-byte packet 0x7F + 0x01 -> 0x80, m_last=1, m_ovf=1, m_cout=0.
REQ-039 SHALL cover: 4-byte 0xFFFFFFFF + 0x00000000, cin=1 -> four 0x00 bytes, m_cout=1 on last.
REQ-040 SHALL cover: 5 bytes without s_last, MAX_BYTES=4 -> 4th output m_last=1, m_trunc=1; 5th byte starts a new packet with fresh carry.
REQ-041 SHALL cover: m_ready low 3 cycles mid-packet -> outputs held, s_ready=0, no byte lost or duplicated.
REQ-042 SHALL cover: rst_n pulsed after byte 2 of a 4-byte packet -> outputs 0 immediately; next packet uses its own s_cin.
